// File: rtl/id_exe_cmd_reg.sv
// ID->EXE pipeline register: unpacks the decoded command bus, gates it with the
// condition check, and handles flush, freeze and bubble. It also counts condition-failed instructions.
module id_exe_cmd_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic              bubble,
   input  logic [8:0]        cmd_in,
   input  logic [3:0]        cond,
   input  logic [3:0]        status,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] val_rn_in,
   input  logic [DATA_W-1:0] val_rm_in,
   input  logic              imm_in,
   input  logic [11:0]       shift_op_in,
   input  logic [23:0]       simm24_in,
   input  logic [3:0]        dest_in,
   output logic              wb_en,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              b,
   output logic              s,
   output logic [3:0]        exe_cmd,
   output logic              valid,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] val_rn,
   output logic [DATA_W-1:0] val_rm,
   output logic              imm,
   output logic [11:0]       shift_op,
   output logic [23:0]       simm24,
   output logic [3:0]        dest,
   output logic [CNT_W-1:0]  fail_cnt
);

   logic              w_n, w_z, w_c, w_v;
   logic              w_cond_pass;
   logic [8:0]        r_cmd;
   logic              r_valid;
   logic [DATA_W-1:0] r_pc, r_val_rn, r_val_rm;
   logic              r_imm;
   logic [11:0]       r_shift_op;
   logic [23:0]       r_simm24;
   logic [3:0]        r_dest;
   logic [CNT_W-1:0]  r_fail_cnt;

   assign {w_n, w_z, w_c, w_v} = status;

   always_comb begin
      w_cond_pass = 1'b0;
      case (cond)
         4'h0: w_cond_pass = w_z;
         4'h1: w_cond_pass = !w_z;
         4'h2: w_cond_pass = w_c;
         4'h3: w_cond_pass = !w_c;
         4'h4: w_cond_pass = w_n;
         4'h5: w_cond_pass = !w_n;
         4'h6: w_cond_pass = w_v;
         4'h7: w_cond_pass = !w_v;
         4'h8: w_cond_pass = w_c && !w_z;
         4'h9: w_cond_pass = !w_c || w_z;
         4'hA: w_cond_pass = (w_n == w_v);
         4'hB: w_cond_pass = (w_n != w_v);
         4'hC: w_cond_pass = !w_z && (w_n == w_v);
         4'hD: w_cond_pass = w_z || (w_n != w_v);
         4'hE: w_cond_pass = 1'b1;
         default: w_cond_pass = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd      <= '0;
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_val_rn   <= '0;
         r_val_rm   <= '0;
         r_imm      <= 1'b0;
         r_shift_op <= '0;
         r_simm24   <= '0;
         r_dest     <= '0;
         r_fail_cnt <= '0;
      end else if (flush) begin
         r_cmd      <= '0;
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_val_rn   <= '0;
         r_val_rm   <= '0;
         r_imm      <= 1'b0;
         r_shift_op <= '0;
         r_simm24   <= '0;
         r_dest     <= '0;
      end else if (!freeze) begin
         if (bubble) begin
            r_cmd   <= '0;
            r_valid <= 1'b0;
         end else begin
            r_pc       <= pc_in;
            r_val_rn   <= val_rn_in;
            r_val_rm   <= val_rm_in;
            r_imm      <= imm_in;
            r_shift_op <= shift_op_in;
            r_simm24   <= simm24_in;
            r_dest     <= dest_in;
            if (w_cond_pass) begin
               r_cmd   <= cmd_in;
               r_valid <= 1'b1;
            end else begin
               // S is squashed with the rest, so a failed instruction never touches flags
               r_cmd   <= '0;
               r_valid <= 1'b0;
               if (r_fail_cnt != {CNT_W{1'b1}})
                  r_fail_cnt <= r_fail_cnt + 1'b1;
            end
         end
      end
   end

   assign wb_en    = r_cmd[8];
   assign mem_r_en = r_cmd[7];
   assign mem_w_en = r_cmd[6];
   assign exe_cmd  = r_cmd[5:2];
   assign b        = r_cmd[1];
   assign s        = r_cmd[0];
   assign valid    = r_valid;
   assign pc       = r_pc;
   assign val_rn   = r_val_rn;
   assign val_rm   = r_val_rm;
   assign imm      = r_imm;
   assign shift_op = r_shift_op;
   assign simm24   = r_simm24;
   assign dest     = r_dest;
   assign fail_cnt = r_fail_cnt;

endmodule
